// File: rtl/boron_pkg.sv
// Shared BORON constants, FSM encoding and nibble S-box tables.
package boron_pkg;

    localparam int unsigned BORON_ROUNDS = 25;
    localparam int unsigned BLOCK_W      = 64;
    localparam int unsigned KEY_W        = 80;
    localparam int unsigned CTR_W        = 5;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] WHITEN = 2'd2;
    localparam logic [1:0] ROUND  = 2'd3;

    // Entry n lives in bits [4n+3:4n]
    localparam logic [63:0] SBOX_TABLE     = 64'h6358_F02D_AC97_1B4E;
    localparam logic [63:0] INV_SBOX_TABLE = 64'hB086_275C_4FD1_E93A;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        return SBOX_TABLE[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] n);
        return INV_SBOX_TABLE[{n, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/dec_key_scheduler.sv
// Inverse BORON key schedule step: undo counter mix and S-box, then rotate right 13.
module dec_key_scheduler import boron_pkg::*; (
    input  logic [CTR_W-1:0] round_counter,
    input  logic [KEY_W-1:0] KEY,
    output logic [KEY_W-1:0] NEXT_KEY
);
    logic [KEY_W-1:0] pre;

    assign pre      = {KEY[79:64], KEY[63:59] ^ round_counter, KEY[58:4], inv_sbox4(KEY[3:0])};
    assign NEXT_KEY = {pre[12:0], pre[79:13]};

endmodule

// File: rtl/enc_key_scheduler.sv
// Forward BORON key schedule step: rotate left 13, S-box low nibble, mix in round counter.
module enc_key_scheduler import boron_pkg::*; (
    input  logic [CTR_W-1:0] round_counter,
    input  logic [KEY_W-1:0] KEY,
    output logic [KEY_W-1:0] NEXT_KEY
);
    logic [KEY_W-1:0] rot;

    assign rot      = {KEY[66:0], KEY[79:67]};
    assign NEXT_KEY = {rot[79:64], rot[63:59] ^ round_counter, rot[58:4], sbox4(rot[3:0])};

endmodule

// File: rtl/inv_block_shuffle.sv
// Swaps the two bytes of every 16-bit word; the shuffle is its own inverse.
module inv_block_shuffle import boron_pkg::*; (
    input  logic [BLOCK_W-1:0] x,
    output logic [BLOCK_W-1:0] y
);
    assign y = {x[55:48], x[63:56],
                x[39:32], x[47:40],
                x[23:16], x[31:24],
                x[7:0],   x[15:8]};

endmodule

// File: rtl/inv_round_permutation.sv
// Rotates each 16-bit word right by 1/4/7/9 (word0..word3), undoing the forward left rotations.
module inv_round_permutation import boron_pkg::*; (
    input  logic [BLOCK_W-1:0] x,
    output logic [BLOCK_W-1:0] y
);
    assign y = {x[56:48], x[63:57],
                x[38:32], x[47:39],
                x[19:16], x[31:20],
                x[0],     x[15:1]};

endmodule

// File: rtl/inv_sbox_layer.sv
// Applies the inverse 4-bit S-box to all sixteen nibbles.
module inv_sbox_layer import boron_pkg::*; (
    input  logic [BLOCK_W-1:0] x,
    output logic [BLOCK_W-1:0] y
);
    always_comb begin
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv_sbox4(x[4*n +: 4]);
        end
    end

endmodule

// File: rtl/inv_xor_operation.sv
// Undoes the suffix-XOR word mix (word3 passes through, each lower word XORed with the one above).
module inv_xor_operation import boron_pkg::*; (
    input  logic [BLOCK_W-1:0] x,
    output logic [BLOCK_W-1:0] y
);
    assign y = {x[63:48],
                x[47:32] ^ x[63:48],
                x[31:16] ^ x[47:32],
                x[15:0]  ^ x[31:16]};

endmodule

// File: rtl/decryption.sv
// Iterative BORON decryptor: expands the key to K25, whitens, then runs 25 inverse rounds.
module decryption import boron_pkg::*; (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] cipher_text,
    input  logic [KEY_W-1:0]   master_key,
    input  logic               dec_start,
    output logic [BLOCK_W-1:0] plain_text,
    output logic               dec_done,
    output logic               dec_busy
);
    localparam logic [CTR_W-1:0] LAST = CTR_W'(BORON_ROUNDS - 1);

    logic [1:0]         state, state_n;
    logic [CTR_W-1:0]   ctr, ctr_n, inv_rc;
    logic [BLOCK_W-1:0] blk, blk_n, plain_n;
    logic [KEY_W-1:0]   key, key_n, ks_fwd, ks_inv;
    logic [BLOCK_W-1:0] ix_out, ip_out, is_out, rinv;
    logic               done_n, busy_n;

    // WHITEN steps K25 back to K24; round i steps Ki back to K(i-1)
    assign inv_rc = (state == WHITEN) ? LAST : ctr - CTR_W'(1);

    enc_key_scheduler u_eks (.round_counter(ctr),    .KEY(key), .NEXT_KEY(ks_fwd));
    dec_key_scheduler u_dks (.round_counter(inv_rc), .KEY(key), .NEXT_KEY(ks_inv));

    inv_xor_operation     u_ixor (.x(blk),    .y(ix_out));
    inv_round_permutation u_iper (.x(ix_out), .y(ip_out));
    inv_block_shuffle     u_ishf (.x(ip_out), .y(is_out));
    inv_sbox_layer        u_isbx (.x(is_out), .y(rinv));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ctr        <= '0;
            blk        <= '0;
            key        <= '0;
            plain_text <= '0;
            dec_done   <= 1'b0;
            dec_busy   <= 1'b0;
        end else begin
            state      <= state_n;
            ctr        <= ctr_n;
            blk        <= blk_n;
            key        <= key_n;
            plain_text <= plain_n;
            dec_done   <= done_n;
            dec_busy   <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        ctr_n   = ctr;
        blk_n   = blk;
        key_n   = key;
        plain_n = plain_text;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                ctr_n = '0;
                if (dec_start) begin
                    blk_n   = cipher_text;
                    key_n   = master_key;
                    state_n = EXPAND;
                end
            end
            EXPAND: begin
                key_n = ks_fwd;
                if (ctr == LAST) state_n = WHITEN;
                else             ctr_n   = ctr + CTR_W'(1);
            end
            WHITEN: begin
                blk_n   = blk ^ key[BLOCK_W-1:0];
                key_n   = ks_inv;
                ctr_n   = LAST;
                state_n = ROUND;
            end
            ROUND: begin
                blk_n = rinv ^ key[BLOCK_W-1:0];
                key_n = ks_inv;
                if (ctr == '0) begin
                    plain_n = rinv ^ key[BLOCK_W-1:0];
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    ctr_n = ctr - CTR_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule
